// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
//   rf_state_e      : clear-sequencer states
//   bytes_per_word  : number of byte lanes in a word of a given width
//   byte_merge      : per-lane merge of an old and a new word under byte enables
// Words up to RF_MAX_DW bits are supported. Callers zero-extend their operands
// and truncate the result back to their own width.
package register_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int RF_MAX_DW = 256;
  localparam int RF_MAX_BE = RF_MAX_DW / 8;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  // Lanes with be[b]=1 take new_w, the rest keep old_w.
  function automatic logic [RF_MAX_DW-1:0] byte_merge(
    input logic [RF_MAX_DW-1:0] old_w,
    input logic [RF_MAX_DW-1:0] new_w,
    input logic [RF_MAX_BE-1:0] be
  );
    logic [RF_MAX_DW-1:0] m;
    m = old_w;
    for (int b = 0; b < RF_MAX_BE; b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/register_file_mp_clear_seq.sv
// Post-reset clear sequencer: sweeps every entry once, issuing a zero write
// per cycle, then idles in READY.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_addr_o     : entry being cleared this cycle
//   clr_we_o       : clear write strobe for clr_addr_o
//   busy_o         : registered, high while the sweep is in progress
module rf_clear_seq
  import register_file_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_we_o,
  output logic                  busy_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  rf_state_e             state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RESET ? RF_CLEAR : RF_READY;
      cnt_q   <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          // The last entry is written on this same edge, so busy drops with it.
          if (cnt_q == LAST_ADDR) begin
            state_q <= RF_READY;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RF_READY;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Suppressed while reset is held so a reset mid-sweep does not write.
  assign clr_we_o   = (state_q == RF_CLEAR) && !rst_i;
  assign clr_addr_o = cnt_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Register file with one byte-enabled write port and NUM_RD_PORTS registered
// read ports. Reads see a same-cycle write to the same address (write-first,
// merged per byte lane). An optional clear sequencer zeroes all entries after
// reset; while it runs, reads and writes are ignored.
//   i_Clk, i_Rst                    : clock, synchronous active-high reset
//   i_Wr_En/_Addr/_Data/_Be         : write port with byte enables
//   i_Rd_En, i_Rd_Addr              : per-port read strobes, packed addresses
//   o_Rd_Data, o_Rd_Valid           : packed registered read data, per-port pulse
//   o_Init_Busy                     : high while the clear sweep runs
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 2,
  parameter int NUM_RD_PORTS   = 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                               i_Clk,
  input  logic                               i_Rst,
  input  logic                               i_Wr_En,
  input  logic [ADDR_WIDTH-1:0]              i_Wr_Addr,
  input  logic [DATA_WIDTH-1:0]              i_Wr_Data,
  input  logic [DATA_WIDTH/8-1:0]            i_Wr_Be,
  input  logic [NUM_RD_PORTS-1:0]            i_Rd_En,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] i_Rd_Addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_Rd_Data,
  output logic [NUM_RD_PORTS-1:0]            o_Rd_Valid,
  output logic                               o_Init_Busy
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD_PORTS-1:0]            rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0]              rd_addr [NUM_RD_PORTS];
  logic [DATA_WIDTH-1:0]              rd_word [NUM_RD_PORTS];

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  busy;
  logic                  ready;

  rf_clear_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i     (i_Clk),
    .rst_i     (i_Rst),
    .clr_addr_o(clr_addr),
    .clr_we_o  (clr_we),
    .busy_o    (busy)
  );

  assign ready = !busy && !i_Rst;

  // Storage: the clear sweep has priority; user writes only when ready.
  always_ff @(posedge i_Clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (ready && i_Wr_En) begin
      for (int b = 0; b < BPW; b++) begin
        if (i_Wr_Be[b]) mem_q[i_Wr_Addr][8*b +: 8] <= i_Wr_Data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_addr[p] = i_Rd_Addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word[p] = mem_q[rd_addr[p]];
      if (i_Wr_En && (i_Wr_Addr == rd_addr[p])) begin
        rd_word[p] = DATA_WIDTH'(byte_merge(RF_MAX_DW'(rd_word[p]),
                                            RF_MAX_DW'(i_Wr_Data),
                                            RF_MAX_BE'(i_Wr_Be)));
      end
      rd_valid_d[p] = ready && i_Rd_En[p];
      if (rd_valid_d[p]) rd_data_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_word[p];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_Rd_Data   = rd_data_q;
  assign o_Rd_Valid  = rd_valid_q;
  assign o_Init_Busy = busy;

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: clear sequencer enabled
  logic        a_rst, a_wr_en, a_busy;
  logic [1:0]  a_wr_addr, a_wr_be, a_rd_en, a_valid;
  logic [15:0] a_wr_data;
  logic [3:0]  a_rd_addr;
  logic [31:0] a_data;

  // Instance B: clear sequencer disabled
  logic        b_rst, b_wr_en, b_busy;
  logic [1:0]  b_wr_addr, b_wr_be, b_rd_en, b_valid;
  logic [15:0] b_wr_data;
  logic [3:0]  b_rd_addr;
  logic [31:0] b_data;

  int nvec = 0;
  int nerr = 0;

  register_file_mp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1'b1)
  ) dut_a (
    .i_Clk(clk), .i_Rst(a_rst), .i_Wr_En(a_wr_en), .i_Wr_Addr(a_wr_addr),
    .i_Wr_Data(a_wr_data), .i_Wr_Be(a_wr_be), .i_Rd_En(a_rd_en),
    .i_Rd_Addr(a_rd_addr), .o_Rd_Data(a_data), .o_Rd_Valid(a_valid),
    .o_Init_Busy(a_busy)
  );

  register_file_mp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(2), .NUM_RD_PORTS(2), .CLEAR_ON_RESET(1'b0)
  ) dut_b (
    .i_Clk(clk), .i_Rst(b_rst), .i_Wr_En(b_wr_en), .i_Wr_Addr(b_wr_addr),
    .i_Wr_Data(b_wr_data), .i_Wr_Be(b_wr_be), .i_Rd_En(b_rd_en),
    .i_Rd_Addr(b_rd_addr), .o_Rd_Data(b_data), .o_Rd_Valid(b_valid),
    .o_Init_Busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_wr(input logic en, input logic [1:0] addr, input logic [15:0] data,
                      input logic [1:0] be);
    a_wr_en = en; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
  endtask

  task automatic a_rd(input logic [1:0] en, input logic [1:0] addr0, input logic [1:0] addr1);
    a_rd_en = en; a_rd_addr = {addr1, addr0};
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_wr(1'b0, 2'd0, 16'h0, 2'b00); a_rd(2'b00, 2'd0, 2'd0);
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
    b_rd_en = '0; b_rd_addr = '0;

    // Reset values
    step();
    chk("a_rst_busy",  {31'd0, a_busy}, 32'd1);
    chk("a_rst_valid", {30'd0, a_valid}, 32'd0);
    chk("a_rst_data",  a_data, 32'h0);
    chk("b_rst_busy",  {31'd0, b_busy}, 32'd0);
    chk("b_rst_valid", {30'd0, b_valid}, 32'd0);
    chk("b_rst_data",  b_data, 32'h0);

    // A: writes/reads issued throughout the sweep must be ignored.
    // B: write in first cycle after reset, read next cycle.
    a_rst = 1'b0; b_rst = 1'b0;
    a_wr(1'b1, 2'd0, 16'hDEAD, 2'b11); a_rd(2'b11, 2'd0, 2'd1);
    b_wr_en = 1'b1; b_wr_addr = 2'd0; b_wr_data = 16'hC0DE; b_wr_be = 2'b11;
    step();
    chk("a_clr1_busy",  {31'd0, a_busy}, 32'd1);
    chk("a_clr1_valid", {30'd0, a_valid}, 32'd0);
    chk("a_clr1_data",  a_data, 32'h0);
    b_wr_en = 1'b0; b_rd_en = 2'b01; b_rd_addr = 4'h0;
    step();
    chk("a_clr2_busy",  {31'd0, a_busy}, 32'd1);
    chk("a_clr2_valid", {30'd0, a_valid}, 32'd0);
    chk("b_rd_data",    b_data, 32'h0000C0DE);
    chk("b_rd_valid",   {30'd0, b_valid}, 32'd1);
    chk("b_busy",       {31'd0, b_busy}, 32'd0);
    b_rd_en = 2'b00;
    step();
    chk("a_clr3_busy",  {31'd0, a_busy}, 32'd1);
    chk("a_clr3_valid", {30'd0, a_valid}, 32'd0);
    chk("b_valid_pulse", {30'd0, b_valid}, 32'd0);
    step();
    chk("a_clr4_busy",  {31'd0, a_busy}, 32'd0);
    chk("a_clr4_valid", {30'd0, a_valid}, 32'd0);
    chk("a_clr4_data",  a_data, 32'h0);

    // Cleared contents
    a_wr(1'b0, 2'd0, 16'h0, 2'b00); a_rd(2'b11, 2'd0, 2'd1);
    step();
    chk("a_clr_rd01_data",  a_data, 32'h0);
    chk("a_clr_rd01_valid", {30'd0, a_valid}, 32'd3);
    a_rd(2'b11, 2'd2, 2'd3);
    step();
    chk("a_clr_rd23_data",  a_data, 32'h0);
    chk("a_clr_rd23_valid", {30'd0, a_valid}, 32'd3);
    a_rd(2'b00, 2'd0, 2'd0);
    step();
    chk("a_idle_valid", {30'd0, a_valid}, 32'd0);

    // Full write then read, one-cycle valid pulse
    a_wr(1'b1, 2'd2, 16'hABCD, 2'b11);
    step();
    a_wr(1'b0, 2'd0, 16'h0, 2'b00); a_rd(2'b01, 2'd2, 2'd0);
    step();
    chk("a_wr2_data",  a_data, 32'h0000ABCD);
    chk("a_wr2_valid", {30'd0, a_valid}, 32'd1);
    a_rd(2'b00, 2'd0, 2'd0);
    step();
    chk("a_wr2_pulse", {30'd0, a_valid}, 32'd0);
    chk("a_wr2_hold",  a_data, 32'h0000ABCD);

    // Partial byte write, then Be=00 no-op (also through the bypass path)
    a_wr(1'b1, 2'd1, 16'h1234, 2'b11);
    step();
    a_wr(1'b1, 2'd1, 16'hFF00, 2'b10);
    step();
    a_wr(1'b0, 2'd0, 16'h0, 2'b00); a_rd(2'b10, 2'd0, 2'd1);
    step();
    chk("a_be10_data",  a_data, 32'hFF34ABCD);
    chk("a_be10_valid", {30'd0, a_valid}, 32'd2);
    a_wr(1'b1, 2'd1, 16'h7777, 2'b00); a_rd(2'b01, 2'd1, 2'd0);
    step();
    chk("a_be00_byp_data", a_data, 32'hFF34FF34);
    a_wr(1'b0, 2'd0, 16'h0, 2'b00); a_rd(2'b11, 2'd1, 2'd1);
    step();
    chk("a_be00_mem_data",  a_data, 32'hFF34FF34);
    chk("a_be00_mem_valid", {30'd0, a_valid}, 32'd3);

    // Write-first bypass, both ports, partial enable
    a_wr(1'b1, 2'd3, 16'h1111, 2'b11); a_rd(2'b00, 2'd0, 2'd0);
    step();
    a_wr(1'b1, 2'd3, 16'h5A5A, 2'b01); a_rd(2'b11, 2'd3, 2'd3);
    step();
    chk("a_byp_data",  a_data, 32'h115A115A);
    chk("a_byp_valid", {30'd0, a_valid}, 32'd3);
    a_wr(1'b0, 2'd0, 16'h0, 2'b00);
    step();
    chk("a_byp_stored", a_data, 32'h115A115A);
    a_rd(2'b00, 2'd0, 2'd0);

    // Reset pulsed on the second clear cycle restarts the sweep
    a_rst = 1'b1;
    step();
    chk("a_rr_busy0", {31'd0, a_busy}, 32'd1);
    chk("a_rr_data0", a_data, 32'h0);
    a_rst = 1'b0;
    step();
    chk("a_rr_busy1", {31'd0, a_busy}, 32'd1);
    a_rst = 1'b1;
    step();
    chk("a_rr_busy2", {31'd0, a_busy}, 32'd1);
    a_rst = 1'b0;
    a_wr(1'b1, 2'd2, 16'h9999, 2'b11); a_rd(2'b11, 2'd2, 2'd2);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("a_rr_sweep%0d_busy", i),  {31'd0, a_busy}, 32'd1);
      chk($sformatf("a_rr_sweep%0d_valid", i), {30'd0, a_valid}, 32'd0);
    end
    step();
    chk("a_rr_done_busy",  {31'd0, a_busy}, 32'd0);
    chk("a_rr_done_valid", {30'd0, a_valid}, 32'd0);
    chk("a_rr_done_data",  a_data, 32'h0);
    a_wr(1'b0, 2'd0, 16'h0, 2'b00); a_rd(2'b11, 2'd2, 2'd1);
    step();
    chk("a_rr_rd_data",  a_data, 32'h0);
    chk("a_rr_rd_valid", {30'd0, a_valid}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
